// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per FU, one registered broadcast per cycle.
// Optional macro CDB_AGE_PRIO_EN selects oldest-ROB-entry-first instead of round-robin.
module cdb_arbiter #(
  parameter int NUM_FU     = 4,
  parameter int PHYS_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int ROB_WIDTH  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 br_flush,
  input  logic [NUM_FU-1:0]                    fu_valid,
  output logic [NUM_FU-1:0]                    fu_ready,
  input  logic [NUM_FU-1:0][PHYS_WIDTH-1:0]    fu_pd,
  input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    fu_data,
  input  logic [NUM_FU-1:0][ROB_WIDTH-1:0]     fu_rob_idx,
  input  logic [ROB_WIDTH-1:0]                 rob_head,
  output logic                                 cdb_valid,
  output logic [PHYS_WIDTH-1:0]                cdb_pd,
  output logic [DATA_WIDTH-1:0]                cdb_data,
  output logic [ROB_WIDTH-1:0]                 cdb_rob_idx,
  output logic [$clog2(NUM_FU)-1:0]            cdb_src
);

  localparam int SRC_W = $clog2(NUM_FU);

  logic [NUM_FU-1:0]     hold_valid;
  logic [NUM_FU-1:0]     hold_next;
  logic [PHYS_WIDTH-1:0] hold_pd   [NUM_FU];
  logic [DATA_WIDTH-1:0] hold_data [NUM_FU];
  logic [ROB_WIDTH-1:0]  hold_rob  [NUM_FU];

  logic [SRC_W-1:0]      rr_ptr;
  logic [SRC_W-1:0]      rr_next;
  logic [SRC_W-1:0]      grant_idx;
  logic                  grant_any;
  logic [NUM_FU-1:0]     grant;
  logic [NUM_FU-1:0]     accept;

`ifdef CDB_AGE_PRIO_EN
  logic [ROB_WIDTH-1:0]  best_age;
  logic [ROB_WIDTH-1:0]  age;

  // Age is distance from the ROB head with wrap; ties keep the lowest index.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    best_age  = '0;
    age       = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      age = hold_rob[i] - rob_head;
      if (hold_valid[i] && (!grant_any || age < best_age)) begin
        grant_any = 1'b1;
        best_age  = age;
        grant_idx = SRC_W'(i);
      end
    end
  end
`else
  logic [SRC_W-1:0]      scan_idx;
  logic                  unused_rob_head;

  assign unused_rob_head = ^rob_head;

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      scan_idx = SRC_W'((int'(rr_ptr) + j) % NUM_FU);
      if (!grant_any && hold_valid[scan_idx]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx;
      end
    end
  end
`endif

  always_comb begin
    grant = '0;
    if (grant_any) grant[grant_idx] = 1'b1;
  end

  assign fu_ready = ~hold_valid | grant;
  assign accept   = fu_valid & fu_ready;
  assign rr_next  = (grant_idx == SRC_W'(NUM_FU - 1)) ? '0 : grant_idx + 1'b1;

  // A granted slot refilled in the same cycle stays valid with the new result.
  always_comb begin
    hold_next = hold_valid;
    for (int i = 0; i < NUM_FU; i++) begin
      if (accept[i])     hold_next[i] = 1'b1;
      else if (grant[i]) hold_next[i] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_valid  <= '0;
      rr_ptr      <= '0;
      cdb_valid   <= 1'b0;
      cdb_pd      <= '0;
      cdb_data    <= '0;
      cdb_rob_idx <= '0;
      cdb_src     <= '0;
    end else if (br_flush) begin
      hold_valid <= '0;
      cdb_valid  <= 1'b0;
    end else begin
      hold_valid <= hold_next;
      cdb_valid  <= grant_any;
      if (grant_any) begin
        cdb_pd      <= hold_pd[grant_idx];
        cdb_data    <= hold_data[grant_idx];
        cdb_rob_idx <= hold_rob[grant_idx];
        cdb_src     <= grant_idx;
        rr_ptr      <= rr_next;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        hold_pd[i]   <= '0;
        hold_data[i] <= '0;
        hold_rob[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (accept[i] && !br_flush) begin
          hold_pd[i]   <= fu_pd[i];
          hold_data[i] <= fu_data[i];
          hold_rob[i]  <= fu_rob_idx[i];
        end
      end
    end
  end

endmodule
